lc3b_mem_responder: RTL and testbench

//  Memory-side responder for the LC-3b core's memory port. Accepts the word

---
 rtl/lc3b_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_lc3b_mem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-port responder: a word array serviced after a fixed latency,
// answering each accepted request with a one-cycle mem_resp pulse.
module lc3b_mem_responder #(
  parameter int    LATENCY   = 3,
  parameter int    ADDR_BITS = 12,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        busy
);

  localparam int         IDX_W    = ADDR_BITS - 1;
  localparam int         WORDS    = 1 << IDX_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         count_q, count_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [1:0]         be_q, be_d;
  logic               resp_q, resp_d;
  logic               busy_q, busy_d;
  logic [15:0]        rdata_q, rdata_d;
  logic [15:0]        mem_q [WORDS];

  logic               req_s;
  logic               commit_s;
  logic               we_s;
  logic               cur_wr_s;
  logic [IDX_W-1:0]   cur_idx_s;
  logic [15:0]        cur_wdata_s;
  logic [1:0]         cur_be_s;
  logic               unused_addr;

  // Bits above the decoded range and bit 0 are deliberately ignored (aliasing).
  assign unused_addr = ^mem_address;
  assign req_s       = mem_read | mem_write;

  // Next-state, transaction capture and commit decode
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_d        = wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    commit_s    = 1'b0;
    cur_wr_s    = wr_q;
    cur_idx_s   = idx_q;
    cur_wdata_s = wdata_q;
    cur_be_s    = be_q;
    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          // write wins when both requests are raised together
          wr_d        = mem_write;
          idx_d       = mem_address[ADDR_BITS-1:1];
          wdata_d     = mem_wdata;
          be_d        = mem_byte_enable;
          count_d     = CNT_INIT;
          cur_wr_s    = mem_write;
          cur_idx_s   = mem_address[ADDR_BITS-1:1];
          cur_wdata_s = mem_wdata;
          cur_be_s    = mem_byte_enable;
          if (CNT_INIT == 4'd0) begin
            state_d  = S_RESP;
            commit_s = 1'b1;
          end else begin
            state_d  = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (!req_s) begin
          state_d = S_IDLE;
        end else if (count_q == 4'd1) begin
          state_d  = S_RESP;
          count_d  = 4'd0;
          commit_s = 1'b1;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        count_d = 4'd0;
      end
    endcase
  end

  // Registered outputs derived from the state being entered
  always_comb begin
    resp_d = (state_d == S_RESP);
    busy_d = (state_d != S_IDLE);
    if (commit_s && !cur_wr_s) begin
      rdata_d = mem_q[cur_idx_s];
    end else begin
      rdata_d = rdata_q;
    end
  end

  assign we_s = commit_s & cur_wr_s & rst_n;

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 16'd0;
      be_q    <= 2'd0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  // Array lanes are updated on the edge entering RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      if (cur_be_s[0]) mem_q[cur_idx_s][7:0]  <= cur_wdata_s[7:0];
      if (cur_be_s[1]) mem_q[cur_idx_s][15:8] <= cur_wdata_s[15:8];
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: directed scenarios plus random traffic on a
// LATENCY=3 and a LATENCY=1 instance, checked against a word-array model.
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd3, wr3, rd1, wr1;
  logic [1:0]  be_in;
  logic [15:0] addr_in, wdata_in;
  logic        resp3, busy3, resp1, busy1;
  logic [15:0] rdata3, rdata1;

  int errors = 0;
  int checks = 0;

  logic [15:0] mm  [2][2048];
  logic [15:0] erd [2];
  logic [10:0] pool [8];

  always #5 clk = ~clk;

  lc3b_mem_responder #(.LATENCY(3), .ADDR_BITS(12)) dut3 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd3), .mem_write(wr3),
    .mem_byte_enable(be_in), .mem_address(addr_in), .mem_wdata(wdata_in),
    .mem_resp(resp3), .mem_rdata(rdata3), .busy(busy3));

  lc3b_mem_responder #(.LATENCY(1), .ADDR_BITS(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
    .mem_byte_enable(be_in), .mem_address(addr_in), .mem_wdata(wdata_in),
    .mem_resp(resp1), .mem_rdata(rdata1), .busy(busy1));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on instance sel (0: latency 3, 1: latency 1), starting next cycle.
  task automatic do_txn(input int sel, input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] be, input bit scramble);
    int          lat = (sel == 0) ? 3 : 1;
    logic [10:0] idx = addr[11:1];
    @(posedge clk); #1;
    addr_in = addr; wdata_in = wd; be_in = be;
    if (sel == 0) begin rd3 = rd; wr3 = wr; end
    else          begin rd1 = rd; wr1 = wr; end
    if (wr) begin
      if (be[0]) mm[sel][idx][7:0]  = wd[7:0];
      if (be[1]) mm[sel][idx][15:8] = wd[15:8];
    end else if (rd) begin
      erd[sel] = mm[sel][idx];
    end
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      chk((c == lat) ? "resp_on_time" : "resp_early",
          16'((sel == 0) ? resp3 : resp1), (c == lat) ? 16'd1 : 16'd0);
      chk("busy_in_service", 16'((sel == 0) ? busy3 : busy1), 16'd1);
      if (scramble && c == 1) begin
        addr_in = ~addr; wdata_in = ~wd; be_in = ~be;
      end
    end
    chk("rdata_resp", (sel == 0) ? rdata3 : rdata1, erd[sel]);
    rd3 = 1'b0; wr3 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
  endtask

  initial begin
    logic [1:0]  t2_be  [3];
    logic [15:0] t2_exp [3];
    t2_be  = '{2'b01, 2'b10, 2'b00};
    t2_exp = '{16'h12CD, 16'hAB34, 16'h1234};

    rst_n = 1'b0; rd3 = 1'b0; wr3 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    be_in = 2'b00; addr_in = 16'h0000; wdata_in = 16'h0000;
    erd[0] = 16'h0000; erd[1] = 16'h0000;
    #12;
    chk("rst_resp3", 16'(resp3), 16'd0);
    chk("rst_busy3", 16'(busy3), 16'd0);
    chk("rst_rdata3", rdata3, 16'h0000);
    chk("rst_resp1", 16'(resp1), 16'd0);
    chk("rst_busy1", 16'(busy1), 16'd0);
    chk("rst_rdata1", rdata1, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    // Full write then read, latency 3
    do_txn(0, 1'b0, 1'b1, 16'h0040, 16'h1234, 2'b11, 1'b0);
    do_txn(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0);
    chk("t1_rdata", rdata3, 16'h1234);
    @(posedge clk); #1;
    chk("t1_idle_resp", 16'(resp3), 16'd0);
    chk("t1_idle_busy", 16'(busy3), 16'd0);

    // Byte-lane writes
    for (int i = 0; i < 3; i++) begin
      do_txn(0, 1'b0, 1'b1, 16'h0040, 16'h1234, 2'b11, 1'b0);
      do_txn(0, 1'b0, 1'b1, 16'h0040, 16'hABCD, t2_be[i], 1'b0);
      do_txn(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0);
      chk("t2_lanes", rdata3, t2_exp[i]);
    end

    // Aliasing above ADDR_BITS and on bit 0
    do_txn(0, 1'b0, 1'b1, 16'h1002, 16'h5555, 2'b11, 1'b0);
    do_txn(0, 1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 1'b0);
    chk("t3_alias_even", rdata3, 16'h5555);
    do_txn(0, 1'b1, 1'b0, 16'h0003, 16'h0000, 2'b00, 1'b0);
    chk("t3_alias_odd", rdata3, 16'h5555);

    // Aborted read then aborted write: no resp, no array or rdata change
    do_txn(0, 1'b0, 1'b1, 16'h0200, 16'h2222, 2'b11, 1'b0);
    @(posedge clk); #1;
    addr_in = 16'h0040; rd3 = 1'b1;
    @(posedge clk); #1;
    chk("t4_busy_c1", 16'(busy3), 16'd1);
    rd3 = 1'b0;
    @(posedge clk); #1;
    chk("t4_busy_c2", 16'(busy3), 16'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("t4_no_resp", 16'(resp3), 16'd0);
    end
    chk("t4_rdata_kept", rdata3, 16'h5555);
    addr_in = 16'h0200; wdata_in = 16'h9999; be_in = 2'b11; wr3 = 1'b1;
    @(posedge clk); #1;
    wr3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("t4_wr_no_resp", 16'(resp3), 16'd0);
    end
    do_txn(0, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b00, 1'b0);
    chk("t4_word_kept", rdata3, 16'h2222);

    // Reset during BUSY of a write
    do_txn(0, 1'b0, 1'b1, 16'h0100, 16'h7777, 2'b11, 1'b0);
    @(posedge clk); #1;
    addr_in = 16'h0100; wdata_in = 16'hBEEF; be_in = 2'b11; wr3 = 1'b1;
    @(posedge clk); #1;
    chk("t5_busy_pre", 16'(busy3), 16'd1);
    rst_n = 1'b0; #1;
    chk("t5_resp_rst", 16'(resp3), 16'd0);
    chk("t5_busy_rst", 16'(busy3), 16'd0);
    chk("t5_rdata_rst", rdata3, 16'h0000);
    wr3 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    erd[0] = 16'h0000; erd[1] = 16'h0000;
    do_txn(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b00, 1'b0);
    chk("t5_word_kept", rdata3, 16'h7777);

    // Latency 1: read+write together, address changed in the response cycle
    do_txn(1, 1'b0, 1'b1, 16'h0300, 16'h1111, 2'b11, 1'b0);
    do_txn(1, 1'b1, 1'b0, 16'h0300, 16'h0000, 2'b00, 1'b0);
    do_txn(1, 1'b1, 1'b1, 16'h0300, 16'h4242, 2'b11, 1'b1);
    chk("t6_rdata_kept", rdata1, 16'h1111);
    do_txn(1, 1'b1, 1'b0, 16'h0300, 16'h0000, 2'b00, 1'b0);
    chk("t6_write_done", rdata1, 16'h4242);

    // Random back-to-back traffic over a small aliased pool
    for (int i = 0; i < 8; i++) pool[i] = 11'($urandom);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++)
        do_txn(s, 1'b0, 1'b1, {4'($urandom), pool[i], 1'b0}, 16'($urandom), 2'b11, 1'b0);
    for (int n = 0; n < 80; n++) begin
      int op  = $urandom_range(0, 2);
      int sel = $urandom_range(0, 1);
      do_txn(sel, op != 1, op != 0,
             {4'($urandom), pool[$urandom_range(0, 7)], 1'($urandom)},
             16'($urandom), 2'($urandom), 1'($urandom));
    end
    @(posedge clk); #1;
    chk("end_idle3", 16'(busy3), 16'd0);
    chk("end_idle1", 16'(busy1), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
